// File: rtl/muldiv_if.sv
// Handshake and result bundle between the execute-stage pipeline and muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             divzero_o;

    modport master (
        output start_i, op_i, a_i, b_i, cancel_i,
        input  busy_o, done_o, hi_o, lo_o, divzero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, cancel_i,
        output busy_o, done_o, hi_o, lo_o, divzero_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing a registered HI/LO pair.
// Divide is restoring radix-2 on magnitudes with a sign fix-up on the last edge.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opa_q, opb_q, rem_q, hi_q, lo_q;
    logic             sgn_q, negq_q, negr_q, done_q, dz_q;

    logic             accept_s, finishing_s, ge_s;
    logic [WIDTH:0]   rem_sh_s, diff_s;
    logic [WIDTH-1:0] rem_d, quo_d, quo_fix_s, rem_fix_s;
    logic [2*WIDTH-1:0] prod_s;

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic sgn);
        logic [2*WIDTH-1:0] ae, be;
        ae = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        be = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ae * be;
    endfunction

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    // Handshake decode; the stall holds through the finishing cycle and drops when done_o rises.
    always_comb begin
        accept_s    = (state_q == IDLE) && bus.start_i && !bus.cancel_i;
        finishing_s = (state_q != IDLE) && (cnt_q == CNT_W'(1));
    end

    assign bus.busy_o    = !bus.cancel_i && (bus.start_i || (state_q != IDLE));
    assign bus.done_o    = done_q;
    assign bus.divzero_o = dz_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;

    // Datapath: one restoring-division step, final sign fix-up and the full product.
    always_comb begin
        rem_sh_s = {rem_q, opa_q[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, opb_q};
        ge_s     = ~diff_s[WIDTH];
        if (ge_s) begin
            rem_d = diff_s[WIDTH-1:0];
        end else begin
            rem_d = rem_sh_s[WIDTH-1:0];
        end
        quo_d     = {opa_q[WIDTH-2:0], ge_s};
        quo_fix_s = negq_q ? neg(quo_d) : quo_d;
        rem_fix_s = negr_q ? neg(rem_d) : rem_d;
        prod_s    = mul_full(opa_q, opb_q, sgn_q);
    end

    // Control FSM and all result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_W'(0);
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!accept_s) begin
                        state_q <= IDLE;
                    end else if (!bus.op_i[1]) begin
                        if (MUL_LAT == 1) begin
                            {hi_q, lo_q} <= mul_full(bus.a_i, bus.b_i, !bus.op_i[0]);
                            done_q       <= 1'b1;
                        end else begin
                            state_q <= MUL;
                            cnt_q   <= CNT_W'(MUL_LAT - 1);
                            opa_q   <= bus.a_i;
                            opb_q   <= bus.b_i;
                            sgn_q   <= !bus.op_i[0];
                        end
                    end else if (bus.b_i == {WIDTH{1'b0}}) begin
                        hi_q   <= bus.a_i;
                        lo_q   <= {WIDTH{1'b1}};
                        done_q <= 1'b1;
                        dz_q   <= 1'b1;
                    end else begin
                        state_q <= DIV;
                        cnt_q   <= CNT_W'(WIDTH);
                        opa_q   <= mag(bus.a_i, !bus.op_i[0]);
                        opb_q   <= mag(bus.b_i, !bus.op_i[0]);
                        rem_q   <= {WIDTH{1'b0}};
                        negq_q  <= !bus.op_i[0] && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                        negr_q  <= !bus.op_i[0] && bus.a_i[WIDTH-1];
                    end
                end
                MUL: begin
                    if (bus.cancel_i) begin
                        state_q <= IDLE;
                        cnt_q   <= CNT_W'(0);
                    end else if (finishing_s) begin
                        {hi_q, lo_q} <= prod_s;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                        cnt_q        <= CNT_W'(0);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV: begin
                    if (bus.cancel_i) begin
                        state_q <= IDLE;
                        cnt_q   <= CNT_W'(0);
                    end else if (finishing_s) begin
                        lo_q    <= quo_fix_s;
                        hi_q    <= rem_fix_s;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= CNT_W'(0);
                    end else begin
                        rem_q <= rem_d;
                        opa_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CNT_W'(0);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=2).
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic rst;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_hi  = '0;
    logic [W-1:0] last_lo  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 (accept).
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input logic edz, input int lat);
        exp_t e;
        bit   got;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        sb_q.push_back('{hi: ehi, lo: elo, dz: edz});
        @(negedge clk);
        chk({tag, "_busy_c0"}, 64'(bus.busy_o), 64'd1);
        chk({tag, "_done_c0"}, 64'(bus.done_o), 64'd0);
        chk({tag, "_hold"}, {bus.hi_o, bus.lo_o}, {last_hi, last_lo});
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (bus.done_o) begin
                got = 1'b1;
                chk({tag, "_latency"}, 64'(c), 64'(lat));
                chk({tag, "_busy_done"}, 64'(bus.busy_o), 64'd0);
                if (sb_q.size() == 0) begin
                    chk({tag, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, "_hi"}, 64'(bus.hi_o), 64'(e.hi));
                    chk({tag, "_lo"}, 64'(bus.lo_o), 64'(e.lo));
                    chk({tag, "_divzero"}, 64'(bus.divzero_o), 64'(e.dz));
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end else begin
                chk({tag, "_busy_run"}, 64'(bus.busy_o), 64'd1);
            end
        end
        if (!got) chk({tag, "_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, {62'd0, bus.done_o, bus.divzero_o}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.cancel_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("reset_flags", {61'd0, bus.done_o, bus.divzero_o, bus.busy_o}, 64'd0);
        @(posedge clk);
        #1;

        do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2);
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 2);
        do_op("mult_nn",   2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'd0, 32'd24, 1'b0, 2);
        do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        do_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        do_op("div_7_m2",  2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
        do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
        do_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 33);
        do_op("divu_zero", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1);

        // Cancel a divide in cycle 10, then accept a multiply in cycle 11.
        bus.start_i = 1'b1;
        bus.op_i    = 2'b10;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("cancel_nodone", 64'(bus.done_o), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.cancel_i = 1'b1;
        @(negedge clk);
        chk("cancel_busy", 64'(bus.busy_o), 64'd0);
        @(posedge clk);
        #1;
        bus.cancel_i = 1'b0;
        do_op("mult_after_cancel", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2);

        // Reset in cycle 5 of a divide.
        bus.start_i = 1'b1;
        bus.op_i    = 2'b11;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            chk("rst_mid_nodone", {62'd0, bus.done_o, bus.busy_o}, 64'd0);
        end
        chk("rst_mid_out", {bus.hi_o, bus.lo_o}, 64'd0);
        @(posedge clk);
        #1;

        // start_i together with cancel_i is not accepted.
        bus.start_i  = 1'b1;
        bus.cancel_i = 1'b1;
        bus.op_i     = 2'b00;
        bus.a_i      = 32'd3;
        bus.b_i      = 32'd3;
        @(negedge clk);
        chk("startcancel_busy", 64'(bus.busy_o), 64'd0);
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.cancel_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("startcancel_idle", {62'd0, bus.done_o, bus.busy_o}, 64'd0);
        end
        chk("startcancel_out", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
